uart_frame_ctrl: RTL
====================

# uart_frame_ctrl

Command/response sequencer for the debug unit's UART. It sits between the UART receive/transmit handshakes and the debug datapath. It turns received bytes into command frames (header plus optional argument) and pulses one command strobe per frame. When a command asks for a response, it serializes the returned word LSB-byte-first through the transmitter, one byte per start/done handshake.

## Interface
Parameters:
- NB_DATA, 8, UART byte width; must equal NB_OP+2
- NB_OP, 6, opcode width
- NB_WORD, 32, response word width; integer multiple of NB_DATA
- TIMEOUT, 1000000, clock cycles allowed between header and argument byte

Ports:
- i_clock  in  1  system clock, all logic on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_rx_data  in  NB_DATA  received byte, valid with i_rx_done_tick
- i_rx_done_tick  in  1  one-cycle strobe, byte received
- o_tx_data  out  NB_DATA  byte to transmit
- o_tx_start  out  1  one-cycle strobe, start transmission of o_tx_data
- i_tx_done_tick  in  1  one-cycle strobe, transmitter finished current byte
- o_cmd_valid  out  1  one-cycle strobe, command fields valid
- o_cmd_op  out  NB_OP  opcode of current command
- o_cmd_arg  out  NB_DATA  argument byte; 0 when the frame has no argument
- i_resp_valid  in  1  one-cycle strobe, i_resp_word valid
- i_resp_word  in  NB_WORD  response word from the datapath
- o_busy  out  1  high whenever the FSM is not in IDLE
- o_frame_err  out  1  one-cycle strobe, argument timeout
- o_drop  out  1  one-cycle strobe, received byte discarded

## Operation
- Header byte layout:
  - bit NB_DATA-1 = HAS_ARG
  - bit NB_DATA-2 = WANT_RESP
  - bits NB_OP-1:0 = opcode
- All outputs are registered. Reset values: every output 0, and the FSM in IDLE.
- FSM states: IDLE, GET_ARG, ISSUE, WAIT_RESP, SEND, WAIT_DONE.
- IDLE: on i_rx_done_tick, latch opcode, HAS_ARG and WANT_RESP, and clear the arg register.
  - HAS_ARG=1: go to GET_ARG and clear the timeout counter.
  - HAS_ARG=0: go to ISSUE.
- GET_ARG:
  - On i_rx_done_tick: latch arg, go to ISSUE.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 without a byte, pulse o_frame_err and return to IDLE.
  - If a byte arrives on the same cycle the counter reaches TIMEOUT-1, the byte wins.
- ISSUE: o_cmd_valid=1 for exactly one cycle, with o_cmd_op and o_cmd_arg stable. Next state is WAIT_RESP if WANT_RESP=1, otherwise IDLE.
- WAIT_RESP: on i_resp_valid, latch i_resp_word, set the byte index to 0, go to SEND. There is no timeout. i_resp_valid outside WAIT_RESP is ignored.
- SEND: o_tx_start=1 for one cycle; o_tx_data = word[idx*NB_DATA +: NB_DATA]. Go to WAIT_DONE.
- WAIT_DONE: on i_tx_done_tick:
  - idx = NB_WORD/NB_DATA-1: go to IDLE.
  - Otherwise idx+1, go to SEND.
- o_tx_data holds its value from SEND until the next SEND.
- Any i_rx_done_tick in ISSUE, WAIT_RESP, SEND or WAIT_DONE: the byte is discarded and o_drop pulses one cycle. The FSM is unaffected.
- o_cmd_op/o_cmd_arg hold their last values until the next frame.
- i_reset asserted mid-frame or mid-transmission: immediate return to IDLE with all outputs 0. A partially sent word is abandoned; no further o_tx_start is issued.

## Timing
- Header without arg, rx_done at cycle t: o_cmd_valid at t+1.
- Arg byte rx_done at t: o_cmd_valid at t+1.
- i_resp_valid at t (in WAIT_RESP): o_tx_start at t+1.
- i_tx_done_tick at t: next o_tx_start at t+1. For the last byte, o_busy falls at t+1.
- Earliest i_resp_valid is accepted is the cycle after o_cmd_valid.
- A new header is accepted on the first cycle after returning to IDLE.
- Timeout: o_frame_err asserts TIMEOUT cycles after the header's rx_done, counting from the cycle after it.

## Test plan
- Reset: hold i_reset with random inputs -> all outputs 0; deassert -> o_busy=0.
- Header 0x05 (no arg, no resp) -> o_cmd_valid one cycle later with op=0x05, arg=0x00; o_busy back to 0 on the following cycle; no o_tx_start.
- Header 0xC3, then arg 0x7A, then i_resp_valid with word 0xDEADBEEF, with the transmitter model returning done 20 cycles after each start -> cmd op=0x03, arg=0x7A; exactly 4 tx_starts with data EF, BE, AD, DE in that order; o_busy low one cycle after the 4th done.
- TIMEOUT=16: header 0x81 with no arg byte -> o_frame_err exactly 16 cycles after the header's rx_done; no o_cmd_valid. Next header 0x02 is then accepted normally.
- Extra rx byte 0x55 during WAIT_DONE -> o_drop one cycle later; the transmitted sequence is unchanged.
- i_reset asserted after the 2nd tx_start of a response -> no further tx_start; after release, header 0x01 yields a normal cmd_valid.

Source files
------------

// File: rtl/uart_frame_ctrl_if.sv
// uart_frame_ctrl_if: bundles the UART rx/tx handshakes, the command strobe
// and the response word of the debug-unit frame controller.
//   slave  : the frame controller's view (consumes i_*, drives o_*)
//   master : the environment's view (drives i_*, consumes o_*)
// Signals:
//   i_rx_data/i_rx_done_tick   received byte + strobe
//   o_tx_data/o_tx_start       byte to send + start strobe
//   i_tx_done_tick             transmitter finished current byte
//   o_cmd_valid/op/arg         decoded command strobe and fields
//   i_resp_valid/i_resp_word   response word from the datapath
//   o_busy/o_frame_err/o_drop  status
interface uart_frame_ctrl_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6,
  parameter int NB_WORD = 32
);
  logic [NB_DATA-1:0] i_rx_data;
  logic               i_rx_done_tick;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_tx_start;
  logic               i_tx_done_tick;
  logic               o_cmd_valid;
  logic [NB_OP-1:0]   o_cmd_op;
  logic [NB_DATA-1:0] o_cmd_arg;
  logic               i_resp_valid;
  logic [NB_WORD-1:0] i_resp_word;
  logic               o_busy;
  logic               o_frame_err;
  logic               o_drop;

  modport slave (
    input  i_rx_data, i_rx_done_tick, i_tx_done_tick, i_resp_valid, i_resp_word,
    output o_tx_data, o_tx_start, o_cmd_valid, o_cmd_op, o_cmd_arg,
           o_busy, o_frame_err, o_drop
  );

  modport master (
    output i_rx_data, i_rx_done_tick, i_tx_done_tick, i_resp_valid, i_resp_word,
    input  o_tx_data, o_tx_start, o_cmd_valid, o_cmd_op, o_cmd_arg,
           o_busy, o_frame_err, o_drop
  );
endinterface

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: command/response sequencer for the debug UART.
// Received bytes form frames: header {HAS_ARG, WANT_RESP, opcode} plus an
// optional argument byte. Each frame pulses o_cmd_valid once. If a response
// is wanted, the returned word is sent LSB byte first, one byte per
// tx start/done handshake.
// Ports:
//   i_clock  system clock (rising edge)
//   i_reset  asynchronous active-high reset
//   bus      uart_frame_ctrl_if.slave (rx, tx, cmd, resp, status signals)
// All outputs are registered decodes of the next state, so every strobe
// appears the cycle after the event that causes it. TIMEOUT must be >= 2.
module uart_frame_ctrl #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6,
  parameter int NB_WORD = 32,
  parameter int TIMEOUT = 1000000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  uart_frame_ctrl_if.slave   bus
);
  localparam int NBYTES = NB_WORD / NB_DATA;
  localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // Counter value whose increment would reach TIMEOUT-1.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);
  localparam logic [IW-1:0] IDX_LAST = IW'(NBYTES - 1);

  typedef enum logic [2:0] {
    IDLE, GET_ARG, ISSUE, WAIT_RESP, SEND, WAIT_DONE
  } state_e;

  state_e                          state_q, state_d;
  logic [NB_OP-1:0]                op_q, op_d;
  logic                            want_q, want_d;
  logic [NB_DATA-1:0]              arg_q, arg_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic [NBYTES-1:0][NB_DATA-1:0]  word_q, word_d;
  logic [IW-1:0]                   idx_q, idx_d;

  logic [NB_DATA-1:0]              tx_data_q, tx_data_d;
  logic                            tx_start_q, tx_start_d;
  logic                            cmd_valid_q, cmd_valid_d;
  logic [NB_OP-1:0]                cmd_op_q, cmd_op_d;
  logic [NB_DATA-1:0]              cmd_arg_q, cmd_arg_d;
  logic                            busy_q, busy_d;
  logic                            frame_err_q, frame_err_d;
  logic                            drop_q, drop_d;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    want_d      = want_q;
    arg_d       = arg_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    idx_d       = idx_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    cmd_valid_d = 1'b0;
    cmd_op_d    = cmd_op_q;
    cmd_arg_d   = cmd_arg_q;
    frame_err_d = 1'b0;
    drop_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.i_rx_done_tick) begin
          op_d   = bus.i_rx_data[NB_OP-1:0];
          want_d = bus.i_rx_data[NB_DATA-2];
          arg_d  = '0;
          if (bus.i_rx_data[NB_DATA-1]) begin
            cnt_d   = '0;
            state_d = GET_ARG;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      GET_ARG: begin
        // A byte on the final counted cycle still wins over the timeout.
        if (bus.i_rx_done_tick) begin
          arg_d   = bus.i_rx_data;
          state_d = ISSUE;
        end else if (cnt_q == CNT_LAST) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ISSUE: begin
        drop_d  = bus.i_rx_done_tick;
        state_d = want_q ? WAIT_RESP : IDLE;
      end
      WAIT_RESP: begin
        drop_d = bus.i_rx_done_tick;
        if (bus.i_resp_valid) begin
          word_d  = bus.i_resp_word;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        drop_d  = bus.i_rx_done_tick;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        drop_d = bus.i_rx_done_tick;
        if (bus.i_tx_done_tick) begin
          if (idx_q == IDX_LAST) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Output strobes are decoded from the next state so they land exactly
    // one cycle after the triggering input.
    if (state_d == ISSUE) begin
      cmd_valid_d = 1'b1;
      cmd_op_d    = op_d;
      cmd_arg_d   = arg_d;
    end
    if (state_d == SEND) begin
      tx_start_d = 1'b1;
      tx_data_d  = word_d[idx_d];
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      want_q      <= 1'b0;
      arg_q       <= '0;
      cnt_q       <= '0;
      word_q      <= '0;
      idx_q       <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= '0;
      cmd_arg_q   <= '0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      want_q      <= want_d;
      arg_q       <= arg_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_op_q    <= cmd_op_d;
      cmd_arg_q   <= cmd_arg_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.o_tx_data   = tx_data_q;
  assign bus.o_tx_start  = tx_start_q;
  assign bus.o_cmd_valid = cmd_valid_q;
  assign bus.o_cmd_op    = cmd_op_q;
  assign bus.o_cmd_arg   = cmd_arg_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_frame_err = frame_err_q;
  assign bus.o_drop      = drop_q;
endmodule
